// File: rtl/f_to_int.sv
// f_to_int: multi-cycle IEEE-754 single-precision to signed int32 converter, STEP bits shifted per cycle.
// Define F_TO_INT_ROUND_EN for round-to-nearest-even; when undefined, results truncate toward zero.
module f_to_int #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf,
    output logic        out_nan
);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN, DONE} state_t;

    localparam logic [4:0]         STEP_AMT = 5'(STEP);
    localparam logic signed [31:0] INT_MAX  = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] INT_MIN  = 32'sh8000_0000;

    state_t             state, state_nxt;
    logic               sign_q, sign_nxt;
    logic               left_q, left_nxt;
    logic [4:0]         rem_q, rem_nxt;
    logic [31:0]        mag_q, mag_nxt;
    logic signed [31:0] res_q, res_nxt;
    logic               ovf_q, ovf_nxt;
    logic               nan_q, nan_nxt;
`ifdef F_TO_INT_ROUND_EN
    logic               grd_q, grd_nxt;
    logic               stk_q, stk_nxt;
`endif

    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_frac;
    logic [4:0]  k_in;
    logic [4:0]  amt;

    assign in_sign = in_data[31];
    assign in_exp  = in_data[30:23];
    assign in_frac = in_data[22:0];

    // On the normal path exp is 127..157, so |exp - 150| is exact in mod-32 arithmetic (150 mod 32 = 22).
    assign k_in = (in_exp > 8'd150) ? (in_exp[4:0] - 5'd22) : (5'd22 - in_exp[4:0]);
    assign amt  = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;

    function automatic logic signed [31:0] saturate(input logic neg);
        return neg ? INT_MIN : INT_MAX;
    endfunction

    function automatic logic signed [31:0] apply_sign(input logic [31:0] m, input logic neg);
        return neg ? -$signed(m) : $signed(m);
    endfunction

`ifdef F_TO_INT_ROUND_EN
    function automatic logic [31:0] round_rne(input logic [31:0] m, input logic g, input logic s);
        return m + {31'd0, g & (s | m[0])};
    endfunction
`endif

    always_comb begin
        state_nxt = state;
        sign_nxt  = sign_q;
        left_nxt  = left_q;
        rem_nxt   = rem_q;
        mag_nxt   = mag_q;
        res_nxt   = res_q;
        ovf_nxt   = ovf_q;
        nan_nxt   = nan_q;
`ifdef F_TO_INT_ROUND_EN
        grd_nxt   = grd_q;
        stk_nxt   = stk_q;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nxt = in_sign;
                    mag_nxt  = {8'd0, 1'b1, in_frac};
                    left_nxt = (in_exp > 8'd150);
                    rem_nxt  = k_in;
`ifdef F_TO_INT_ROUND_EN
                    grd_nxt  = 1'b0;
                    stk_nxt  = 1'b0;
`endif
                    if (in_exp == 8'hFF) begin
                        nan_nxt   = |in_frac;
                        ovf_nxt   = ~|in_frac;
                        res_nxt   = (|in_frac) ? '0 : saturate(in_sign);
                        state_nxt = DONE;
                    end else if (in_exp < 8'd127) begin
                        res_nxt   = '0;
                        state_nxt = DONE;
                    end else if (in_exp > 8'd157) begin
                        // -2^31 is the one exactly representable value in this range
                        ovf_nxt   = (in_data != 32'hCF00_0000);
                        res_nxt   = saturate(in_sign);
                        state_nxt = DONE;
                    end else begin
                        state_nxt = (k_in == 5'd0) ? FIN : SHIFT;
                    end
                end
            end
            SHIFT: begin
                rem_nxt = rem_q - amt;
                if (left_q) begin
                    mag_nxt = mag_q << amt;
                end else begin
`ifdef F_TO_INT_ROUND_EN
                    for (int i = 0; i < STEP; i++) begin
                        if (5'(i) < amt) begin
                            stk_nxt = stk_nxt | grd_nxt;
                            grd_nxt = mag_nxt[0];
                            mag_nxt = mag_nxt >> 1;
                        end
                    end
`else
                    mag_nxt = mag_q >> amt;
`endif
                end
                if (rem_nxt == 5'd0) state_nxt = FIN;
            end
            FIN: begin
`ifdef F_TO_INT_ROUND_EN
                res_nxt = apply_sign(round_rne(mag_q, grd_q, stk_q), sign_q);
`else
                res_nxt = apply_sign(mag_q, sign_q);
`endif
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    res_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    nan_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sign_q <= 1'b0;
            left_q <= 1'b0;
            rem_q  <= '0;
            mag_q  <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            nan_q  <= 1'b0;
`ifdef F_TO_INT_ROUND_EN
            grd_q  <= 1'b0;
            stk_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            sign_q <= sign_nxt;
            left_q <= left_nxt;
            rem_q  <= rem_nxt;
            mag_q  <= mag_nxt;
            res_q  <= res_nxt;
            ovf_q  <= ovf_nxt;
            nan_q  <= nan_nxt;
`ifdef F_TO_INT_ROUND_EN
            grd_q  <= grd_nxt;
            stk_q  <= stk_nxt;
`endif
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = res_q;
    assign out_ovf   = ovf_q;
    assign out_nan   = nan_q;

endmodule

// File: tb/tb_f_to_int.sv
// Directed testbench for f_to_int: one STEP=1 instance and one STEP=4 instance sharing clk/rst.
`timescale 1ns/1ps
module tb_f_to_int;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf, a_out_nan;
    logic [31:0] a_in_data, a_out_data;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_out_nan;
    logic [31:0] b_in_data, b_out_data;

    int tests  = 0;
    int failed = 0;

`ifdef F_TO_INT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    f_to_int #(.STEP(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_ovf(a_out_ovf), .out_nan(a_out_nan)
    );

    f_to_int #(.STEP(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ovf(b_out_ovf), .out_nan(b_out_nan)
    );

    // Latency counts the acceptance edge as 1.
    task automatic run_a(input logic [31:0] d, input bit consume, output logic [31:0] res,
                         output logic ovf, output logic nan, output int lat);
        int n = 0;
        while (!a_in_ready && n < 100) begin @(posedge clk); #1; n++; end
        a_in_data  = d;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_data  = $urandom;
        lat = 1;
        while (!a_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        res = a_out_data;
        ovf = a_out_ovf;
        nan = a_out_nan;
        if (!a_out_valid) lat = -1;
        if (consume && a_out_ready) begin @(posedge clk); #1; end
    endtask

    task automatic run_b(input logic [31:0] d, output logic [31:0] res,
                         output logic ovf, output logic nan, output int lat);
        int n = 0;
        while (!b_in_ready && n < 100) begin @(posedge clk); #1; n++; end
        b_in_data  = d;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_in_data  = $urandom;
        lat = 1;
        while (!b_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        res = b_out_data;
        ovf = b_out_ovf;
        nan = b_out_nan;
        if (!b_out_valid) lat = -1;
        if (b_out_ready) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({a_out_valid, a_out_ovf, a_out_nan, b_out_valid} !== 4'b0000) begin
            failed++;
            $display("FAIL reset_flags: got %b expected 0000", {a_out_valid, a_out_ovf, a_out_nan, b_out_valid});
        end
        tests++;
        if (a_out_data !== 32'h0) begin
            failed++;
            $display("FAIL reset_data: got %h expected 00000000", a_out_data);
        end
        rst = 1'b0;
        tests++;
        if ({a_in_ready, b_in_ready} !== 2'b11) begin
            failed++;
            $display("FAIL reset_in_ready: got %b expected 11", {a_in_ready, b_in_ready});
        end
    endtask

    task automatic test_rounding();
        logic [31:0] ops  [9] = '{32'h3F800000, 32'h40600000, 32'hC0200000, 32'h40200000, 32'h40200001,
                                  32'h3FC00000, 32'hBFE00000, 32'h3FFFFFFF, 32'h41200000};
        logic [31:0] expd [9] = '{32'd1, RND ? 32'd4 : 32'd3, 32'hFFFFFFFE, 32'd2, RND ? 32'd3 : 32'd2,
                                  RND ? 32'd2 : 32'd1, RND ? 32'hFFFFFFFE : 32'hFFFFFFFF,
                                  RND ? 32'd2 : 32'd1, 32'd10};
        int          lats [9] = '{25, 24, 24, 24, 24, 25, 25, 25, 22};
        logic [31:0] res;
        logic        ovf, nan;
        int          lat;
        a_out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_a(ops[i], 1'b1, res, ovf, nan, lat);
            tests++;
            if (res !== expd[i]) begin
                failed++;
                $display("FAIL normal_data[%h]: got %h expected %h", ops[i], res, expd[i]);
            end
            tests++;
            if ({ovf, nan} !== 2'b00) begin
                failed++;
                $display("FAIL normal_flags[%h]: got %b expected 00", ops[i], {ovf, nan});
            end
            tests++;
            if (lat != lats[i]) begin
                failed++;
                $display("FAIL normal_latency[%h]: got %0d expected %0d", ops[i], lat, lats[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] ops  [10] = '{32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h4F000000, 32'hCF000000,
                                   32'hCF000001, 32'h3F000000, 32'h00000001, 32'h4EFFFFFF, 32'hCEFFFFFF};
        logic [31:0] expd [10] = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000,
                                   32'h80000000, 32'h0, 32'h0, 32'h7FFFFF80, 32'h80000080};
        logic [1:0]  flg  [10] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        int          lats [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 9, 9};
        logic [31:0] res;
        logic        ovf, nan;
        int          lat;
        a_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_a(ops[i], 1'b1, res, ovf, nan, lat);
            tests++;
            if (res !== expd[i]) begin
                failed++;
                $display("FAIL special_data[%h]: got %h expected %h", ops[i], res, expd[i]);
            end
            tests++;
            if ({ovf, nan} !== flg[i]) begin
                failed++;
                $display("FAIL special_flags[%h]: got ovf,nan=%b expected %b", ops[i], {ovf, nan}, flg[i]);
            end
            tests++;
            if (lat != lats[i]) begin
                failed++;
                $display("FAIL special_latency[%h]: got %0d expected %0d", ops[i], lat, lats[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] res;
        logic        ovf, nan;
        int          lat;
        int          bad = 0;
        a_out_ready = 1'b0;
        run_a(32'h4B000000, 1'b0, res, ovf, nan, lat);
        tests++;
        if (res !== 32'h00800000 || lat != 2) begin
            failed++;
            $display("FAIL hold_result: got %h lat %0d expected 00800000 lat 2", res, lat);
        end
        a_in_data  = 32'h3F800000;
        a_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (a_out_valid !== 1'b1 || a_out_data !== 32'h00800000 || a_in_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        tests++;
        if ({a_out_valid, a_out_ovf, a_out_nan, a_in_ready} !== 4'b0001 || a_out_data !== 32'h0) begin
            failed++;
            $display("FAIL hold_release: got vld,ovf,nan,rdy=%b data=%h expected 0001 data=00000000",
                     {a_out_valid, a_out_ovf, a_out_nan, a_in_ready}, a_out_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        ovf, nan;
        int          lat;
        int          seen = 0;
        a_out_ready = 1'b1;
        a_in_data   = 32'h3F800000;
        a_in_valid  = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        tests++;
        if (a_in_ready !== 1'b0) begin
            failed++;
            $display("FAIL mid_busy: got in_ready %b expected 0", a_in_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({a_in_ready, a_out_valid, a_out_ovf, a_out_nan} !== 4'b1000 || a_out_data !== 32'h0) begin
            failed++;
            $display("FAIL mid_reset_state: got rdy,vld,ovf,nan=%b data=%h expected 1000 data=00000000",
                     {a_in_ready, a_out_valid, a_out_ovf, a_out_nan}, a_out_data);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (a_out_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            failed++;
            $display("FAIL mid_discard: got %0d out_valid cycles expected 0", seen);
        end
        run_a(32'h40000000, 1'b1, res, ovf, nan, lat);
        tests++;
        if (res !== 32'd2 || lat != 24) begin
            failed++;
            $display("FAIL mid_next: got %h lat %0d expected 00000002 lat 24", res, lat);
        end
    endtask

    task automatic test_step4();
        logic [31:0] ops  [4] = '{32'h3F800000, 32'h40600000, 32'hC0200000, 32'h4EFFFFFF};
        logic [31:0] expd [4] = '{32'd1, RND ? 32'd4 : 32'd3, 32'hFFFFFFFE, 32'h7FFFFF80};
        int          lats [4] = '{8, 8, 8, 4};
        logic [31:0] res;
        logic        ovf, nan;
        int          lat;
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_b(ops[i], res, ovf, nan, lat);
            tests++;
            if (res !== expd[i] || {ovf, nan} !== 2'b00) begin
                failed++;
                $display("FAIL step4_data[%h]: got %h flags %b expected %h flags 00", ops[i], res, {ovf, nan}, expd[i]);
            end
            tests++;
            if (lat != lats[i]) begin
                failed++;
                $display("FAIL step4_latency[%h]: got %0d expected %0d", ops[i], lat, lats[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops  [4] = '{32'h40000000, 32'hC0400000, 32'h42C80000, 32'h7FC00000};
        logic [31:0] expd [4] = '{32'd2, 32'hFFFFFFFD, 32'd100, 32'h0};
        logic        expn [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int          idx  = 0;
        int          ridx = 0;
        int          both = 0;
        logic        acc;
        b_out_ready = 1'b1;
        b_in_data   = ops[0];
        b_in_valid  = 1'b1;
        for (int c = 0; c < 300 && ridx < 4; c++) begin
            acc = b_in_valid && b_in_ready;
            if (b_in_ready && b_out_valid) both++;
            if (b_out_valid) begin
                tests++;
                if (b_out_data !== expd[ridx] || b_out_nan !== expn[ridx]) begin
                    failed++;
                    $display("FAIL b2b_result[%0d]: got %h nan %b expected %h nan %b",
                             ridx, b_out_data, b_out_nan, expd[ridx], expn[ridx]);
                end
                ridx++;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) b_in_data = ops[idx];
                else b_in_valid = 1'b0;
            end
        end
        b_in_valid = 1'b0;
        tests++;
        if (ridx != 4 || idx != 4 || both != 0) begin
            failed++;
            $display("FAIL b2b_count: got results %0d accepts %0d overlap %0d expected 4 4 0", ridx, idx, both);
        end
    endtask

    initial begin
        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_in_data   = 32'h0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = 32'h0;
        b_out_ready = 1'b1;
        test_reset();
        test_rounding();
        test_specials();
        test_hold();
        test_reset_mid();
        test_step4();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/f_to_int.md
F_TO_INT -- requirements
Module: f_to_int

Interface
REQ-001 SHALL have parameter STEP, default 1, mantissa bit positions shifted per SHIFT cycle (legal 1, 2, 4, 8).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  in_data holds an operand.
REQ-005 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-006 SHALL have port in_data  input  32  IEEE-754 single-precision operand.
REQ-007 SHALL have port out_valid  output  1  out_data and flags hold a result.
REQ-008 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-009 SHALL have port out_data  output  32  signed two's-complement integer result.
REQ-010 SHALL have port out_ovf  output  1  result saturated (infinity or out of range).
REQ-011 SHALL have port out_nan  output  1  operand was NaN.

Function
REQ-012 SHALL implement states IDLE, SHIFT, FIN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-013 SHALL accept an operand when in_valid & in_ready, registering sign, exponent field E and mantissa {1, frac} in a 32-bit working register; e = E - 127.
REQ-014 SHALL classify special cases at acceptance and go IDLE -> DONE, so out_valid rises one cycle after acceptance.
REQ-015 Specials: NaN (E=255, frac!=0) -> 0, nan=1; infinity -> 0x7FFFFFFF or 0x80000000 by sign, ovf=1; E=0 or e<0 -> 0, no flags.
REQ-016 SHALL treat e>=31 as overflow: saturate as infinity, ovf=1, except 0xCF000000, which yields 0x80000000 with ovf=0.
REQ-017 Normal case (0<=e<=30): shift count k=|e-23|, direction left if e>23, else right; k=0 goes IDLE -> FIN, else IDLE -> SHIFT.
REQ-018 In SHIFT, each cycle SHALL shift by min(STEP, remaining k) and decrement remaining; remaining reaching 0 -> FIN.
REQ-019 FIN SHALL apply rounding (REQ-027) then negate if sign=1, load out_data, and go to DONE.
REQ-020 Normal-case latency SHALL be ceil(k/STEP)+2 cycles from the acceptance edge to out_valid.
REQ-021 DONE SHALL hold out_data, out_ovf and out_nan stable until out_ready=1; DONE & out_ready -> IDLE; no new acceptance in that same cycle.
REQ-022 out_data, out_ovf and out_nan SHALL be 0 whenever out_valid=0.
REQ-023 in_data SHALL be ignored except in the acceptance cycle; changing it mid-operation has no effect.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE and clear out_valid, out_data, out_ovf, out_nan and all working registers to 0.
REQ-025 rst asserted mid-SHIFT, FIN or DONE SHALL discard the in-flight operand; no result is ever presented for it.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro F_TO_INT_ROUND_EN SHALL select rounding; defined: track guard (last bit shifted out) and sticky (OR of earlier bits shifted out) during right shifts, and in FIN increment the magnitude when guard & (sticky | lsb), i.e. round-to-nearest-even; undefined: truncate toward zero with no guard/sticky logic.
REQ-028 Rounding SHALL never change latency or flags.

Verification
REQ-029 STEP=1, 0x3F800000 (1.0), out_ready=1 -> out_data=1, flags 0, out_valid 25 cycles after acceptance.
REQ-030 0x40600000 (3.5) -> 3 without macro, 4 with it; 0xC0200000 (-2.5) -> 0xFFFFFFFE both builds.
REQ-031 0x7FC00000 -> out_data=0, out_nan=1, one-cycle latency; 0x4F000000 -> 0x7FFFFFFF, out_ovf=1; 0xCF000000 -> 0x80000000, out_ovf=0.
REQ-032 0x4B000000 (8388608.0) -> 0x00800000 after 2 cycles; hold out_ready=0 for 10 cycles -> result stable, in_ready=0 throughout.
REQ-033 rst pulsed during SHIFT of 0x3F800000 -> IDLE next cycle, outputs 0, no out_valid; next operand 0x40000000 -> 2.
REQ-034 STEP=4, 0x3F800000 -> 1 after 8 cycles; back-to-back operands with in_valid held high -> each accepted only in IDLE, results in order.
